// File: rtl/ntt_address_unit_param_if.sv
// Handshake/address bundle between the NTT controller and the parametrised address unit.
// The slave modport is the address unit's view of the bus.
interface ntt_address_unit_param_if #(
  parameter int LOG_N = 5
);
  logic                    start;
  logic                    inverse;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic [3:0]              stage_o;
  logic [LOG_N-2:0]        j_o;
  logic                    update_m;
  logic                    update_omega;
  logic                    rd_valid;
  logic [LOG_N-1:0]        raddr1_o;
  logic [LOG_N-1:0]        raddr2_o;
  logic                    wr_valid;
  logic [LOG_N-1:0]        waddr1_o;
  logic [LOG_N-1:0]        waddr2_o;
  logic [(1<<LOG_N)-1:0]   we_o;

  modport master (
    output start, inverse, stall,
    input  busy, done, stage_o, j_o, update_m, update_omega,
    input  rd_valid, raddr1_o, raddr2_o, wr_valid, waddr1_o, waddr2_o, we_o
  );

  modport slave (
    input  start, inverse, stall,
    output busy, done, stage_o, j_o, update_m, update_omega,
    output rd_valid, raddr1_o, raddr2_o, wr_valid, waddr1_o, waddr2_o, we_o
  );
endinterface

// File: rtl/ntt_address_unit_param.sv
// Radix-2 in-place NTT/INTT butterfly address generator for N = 2**LOG_N points,
// with stall back-pressure and a BF_LAT-deep write-address delay line.
module ntt_address_unit_param #(
  parameter int LOG_N  = 5,
  parameter int BF_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ntt_address_unit_param_if.slave bus
);
  localparam int                N          = 1 << LOG_N;
  localparam logic [LOG_N:0]    M_TWO      = (LOG_N+1)'(2);
  localparam logic [LOG_N:0]    M_FULL     = (LOG_N+1)'(N);
  localparam logic [LOG_N-1:0]  ADDR_ONE   = LOG_N'(1);
  localparam logic [LOG_N-2:0]  J_ONE      = (LOG_N-1)'(1);
  localparam logic [3:0]        LAST_STAGE = 4'(LOG_N - 1);

  typedef enum logic [1:0] {IDLE, CONF, RND, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              inverse_q, inverse_d;
  logic [LOG_N:0]    m_q, m_d;
  logic [LOG_N-2:0]  j_q, j_d;
  logic [LOG_N-1:0]  k_q, k_d;
  logic [3:0]        stage_q, stage_d;
  logic              rd_valid_q, rd_valid_d;
  logic [LOG_N-1:0]  raddr1_q, raddr1_d;
  logic [LOG_N-1:0]  raddr2_q, raddr2_d;
  logic              update_m_q, update_m_d;
  logic              update_omega_q, update_omega_d;
  logic              done_q, done_d;
  logic [BF_LAT-1:0] dl_valid_q, dl_valid_d;
  logic [LOG_N-1:0]  dl_a1_q [BF_LAT];
  logic [LOG_N-1:0]  dl_a1_d [BF_LAT];
  logic [LOG_N-1:0]  dl_a2_q [BF_LAT];
  logic [LOG_N-1:0]  dl_a2_d [BF_LAT];

  logic [LOG_N-1:0]  half, a1, a2;
  logic [LOG_N:0]    k_sum;
  logic              k_last, j_last, last_bf, issue, pending;
  logic [N-1:0]      we;

  assign half    = m_q[LOG_N:1];
  assign a1      = k_q + {1'b0, j_q};
  assign a2      = a1 + half;
  assign k_sum   = {1'b0, k_q} + m_q;
  assign k_last  = (k_sum == M_FULL);
  assign j_last  = ({1'b0, j_q} == half - ADDR_ONE);
  assign last_bf = k_last && j_last && (stage_q == LAST_STAGE);
  assign issue   = (state_q == RND) && !bus.stall;

  always_comb begin
    state_d        = state_q;
    inverse_d      = inverse_q;
    m_d            = m_q;
    j_d            = j_q;
    k_d            = k_q;
    stage_d        = stage_q;
    rd_valid_d     = issue;
    raddr1_d       = raddr1_q;
    raddr2_d       = raddr2_q;
    update_m_d     = 1'b0;
    update_omega_d = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          inverse_d = bus.inverse;
          state_d   = CONF;
        end
      end
      CONF: begin
        m_d     = inverse_q ? M_FULL : M_TWO;
        j_d     = '0;
        k_d     = '0;
        stage_d = '0;
        state_d = RND;
      end
      RND: begin
        // Pulses ride with the pair they belong to; the very first group's omega comes from the m reload.
        if (issue) begin
          raddr1_d       = a1;
          raddr2_d       = a2;
          update_m_d     = (j_q == '0) && (k_q == '0);
          update_omega_d = (k_q == '0) && !((stage_q == 4'd0) && (j_q == '0));
          if (last_bf) begin
            state_d = DRAIN;
          end else if (!k_last) begin
            k_d = k_sum[LOG_N-1:0];
          end else begin
            k_d = '0;
            if (!j_last) begin
              j_d = j_q + J_ONE;
            end else begin
              j_d     = '0;
              m_d     = inverse_q ? (m_q >> 1) : (m_q << 1);
              stage_d = stage_q + 4'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (!pending) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Invalid slots carry zero addresses so the write side reads 0 during bubbles.
  always_comb begin
    dl_valid_d[0] = rd_valid_q;
    dl_a1_d[0]    = rd_valid_q ? raddr1_q : '0;
    dl_a2_d[0]    = rd_valid_q ? raddr2_q : '0;
    for (int i = 1; i < BF_LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_a1_d[i]    = dl_a1_q[i-1];
      dl_a2_d[i]    = dl_a2_q[i-1];
    end
    pending = rd_valid_q;
    for (int i = 0; i < BF_LAT - 1; i++) begin
      pending = pending | dl_valid_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      inverse_q      <= 1'b0;
      m_q            <= M_TWO;
      j_q            <= '0;
      k_q            <= '0;
      stage_q        <= '0;
      rd_valid_q     <= 1'b0;
      raddr1_q       <= '0;
      raddr2_q       <= '0;
      update_m_q     <= 1'b0;
      update_omega_q <= 1'b0;
      done_q         <= 1'b0;
      dl_valid_q     <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a1_q[i] <= '0;
        dl_a2_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      inverse_q      <= inverse_d;
      m_q            <= m_d;
      j_q            <= j_d;
      k_q            <= k_d;
      stage_q        <= stage_d;
      rd_valid_q     <= rd_valid_d;
      raddr1_q       <= raddr1_d;
      raddr2_q       <= raddr2_d;
      update_m_q     <= update_m_d;
      update_omega_q <= update_omega_d;
      done_q         <= done_d;
      dl_valid_q     <= dl_valid_d;
      for (int i = 0; i < BF_LAT; i++) begin
        dl_a1_q[i] <= dl_a1_d[i];
        dl_a2_q[i] <= dl_a2_d[i];
      end
    end
  end

  always_comb begin
    we = '0;
    if (dl_valid_q[BF_LAT-1]) begin
      we[dl_a1_q[BF_LAT-1]] = 1'b1;
      we[dl_a2_q[BF_LAT-1]] = 1'b1;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.stage_o      = stage_q;
  assign bus.j_o          = j_q;
  assign bus.update_m     = update_m_q;
  assign bus.update_omega = update_omega_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.raddr1_o     = raddr1_q;
  assign bus.raddr2_o     = raddr2_q;
  assign bus.wr_valid     = dl_valid_q[BF_LAT-1];
  assign bus.waddr1_o     = dl_a1_q[BF_LAT-1];
  assign bus.waddr2_o     = dl_a2_q[BF_LAT-1];
  assign bus.we_o         = we;
endmodule

// File: tb/tb_ntt_address_unit_param.sv
// Directed bench for ntt_address_unit_param: one BF_LAT=1 and one BF_LAT=4 instance
// share the same stimulus; expected addresses come from a loop-nest reference model.
module tb_ntt_address_unit_param;
  localparam int LOG_N  = 5;
  localparam int N      = 1 << LOG_N;
  localparam int NPAIRS = LOG_N * N / 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic inverse;
  logic stall;

  always #5 clk = ~clk;

  ntt_address_unit_param_if #(.LOG_N(LOG_N)) bus1 ();
  ntt_address_unit_param_if #(.LOG_N(LOG_N)) bus4 ();

  assign bus1.start   = start;
  assign bus1.inverse = inverse;
  assign bus1.stall   = stall;
  assign bus4.start   = start;
  assign bus4.inverse = inverse;
  assign bus4.stall   = stall;

  ntt_address_unit_param #(.LOG_N(LOG_N), .BF_LAT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  ntt_address_unit_param #(.LOG_N(LOG_N), .BF_LAT(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  int nChecks = 0;
  int nFail   = 0;

  int histV  [1024];
  int histA1 [1024];
  int histA2 [1024];
  int holdA1 = 0;
  int holdA2 = 0;

  int obsRd, obsUm, obsUo, obsDone1, obsDone4, obsGap;
  int pairFirst, pairSecond, pairLast, pairResume;
  int runFinished;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input bit inv);
    start   = 1'b1;
    inverse = inv;
    tick();
    start   = 1'b0;
    inverse = ~inv;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_flags1"}, 32'({bus1.busy, bus1.done, bus1.rd_valid, bus1.wr_valid, bus1.update_m, bus1.update_omega}), 32'd0);
    checkOutput({tag, "_raddr1"}, 32'({bus1.raddr1_o, bus1.raddr2_o}), 32'd0);
    checkOutput({tag, "_waddr1"}, 32'({bus1.waddr1_o, bus1.waddr2_o}), 32'd0);
    checkOutput({tag, "_we1"}, 32'(bus1.we_o), 32'd0);
    checkOutput({tag, "_stage_j1"}, 32'({bus1.stage_o, bus1.j_o}), 32'd0);
    checkOutput({tag, "_flags4"}, 32'({bus4.busy, bus4.done, bus4.rd_valid, bus4.wr_valid}), 32'd0);
    checkOutput({tag, "_we4"}, 32'(bus4.we_o), 32'd0);
  endtask

  task automatic runTransform(input bit inv, input int stallAfter, input int restartCycle, input int abortAfter);
    int  expA1[$];
    int  expA2[$];
    bit  expUm[$];
    bit  expUo[$];
    int  m, half, issued, cyc, lastRd, stallLeft, ea1, ea2, enc, h1, h4;
    bit  issueNext, expV, eum, euo, prevV;
    logic [31:0] we1, we4;

    m = inv ? N : 2;
    for (int s = 0; s < LOG_N; s++) begin
      half = m / 2;
      for (int j = 0; j < half; j++) begin
        for (int k = 0; k < N; k += m) begin
          expA1.push_back(k + j);
          expA2.push_back(k + j + half);
          expUm.push_back((j == 0) && (k == 0));
          expUo.push_back((k == 0) && !((s == 0) && (j == 0)));
        end
      end
      m = inv ? m / 2 : m * 2;
    end
    for (int i = 0; i < 1024; i++) begin
      histV[i]  = 0;
      histA1[i] = 0;
      histA2[i] = 0;
    end
    obsRd = 0; obsUm = 0; obsUo = 0; obsDone1 = 0; obsDone4 = 0; obsGap = 0;
    pairFirst = -1; pairSecond = -1; pairLast = -1; pairResume = -1;
    runFinished = 0;

    applyStimulus(inv);
    checkOutput("busy_conf", 32'({bus1.busy, bus4.busy}), 32'd3);
    checkOutput("rd_valid_conf", 32'(bus1.rd_valid), 32'd0);
    tick();
    cyc = 0;
    checkOutput("rd_valid_rnd0", 32'(bus1.rd_valid), 32'd0);

    issued = 0; lastRd = -100; stallLeft = 0; stall = 1'b0;
    ea1 = holdA1; ea2 = holdA2; prevV = 1'b0;
    for (int iter = 0; iter < 400; iter++) begin
      issueNext = !stall && (issued < NPAIRS);
      tick();
      cyc++;
      expV = issueNext;
      eum  = 1'b0;
      euo  = 1'b0;
      if (expV) begin
        ea1 = expA1[issued];
        ea2 = expA2[issued];
        eum = expUm[issued];
        euo = expUo[issued];
        issued++;
        if (issued == NPAIRS) lastRd = cyc;
      end
      histV[cyc+8]  = int'(expV);
      histA1[cyc+8] = expV ? ea1 : 0;
      histA2[cyc+8] = expV ? ea2 : 0;

      checkOutput("rd_valid", 32'(bus1.rd_valid), 32'(expV));
      checkOutput("raddr1", 32'(bus1.raddr1_o), 32'(ea1));
      checkOutput("raddr2", 32'(bus1.raddr2_o), 32'(ea2));
      checkOutput("update_m", 32'(bus1.update_m), 32'(eum));
      checkOutput("update_omega", 32'(bus1.update_omega), 32'(euo));

      if (bus1.rd_valid) begin
        obsRd++;
        enc = int'(bus1.raddr1_o) * 100 + int'(bus1.raddr2_o);
        if (obsRd == 1) pairFirst = enc;
        if (obsRd == 2) pairSecond = enc;
        if (!prevV && obsRd > 1) pairResume = enc;
        pairLast = enc;
      end else if (obsRd > 0 && obsRd < NPAIRS) begin
        obsGap++;
      end
      prevV = bus1.rd_valid;
      obsUm += int'(bus1.update_m);
      obsUo += int'(bus1.update_omega);

      h1  = cyc + 8 - 1;
      h4  = cyc + 8 - 4;
      we1 = (histV[h1] != 0) ? ((32'd1 << histA1[h1]) | (32'd1 << histA2[h1])) : 32'd0;
      we4 = (histV[h4] != 0) ? ((32'd1 << histA1[h4]) | (32'd1 << histA2[h4])) : 32'd0;
      checkOutput("wr_valid_lat1", 32'(bus1.wr_valid), 32'(histV[h1]));
      checkOutput("waddr_lat1", 32'({bus1.waddr1_o, bus1.waddr2_o}), 32'(histA1[h1] * 32 + histA2[h1]));
      checkOutput("we_lat1", 32'(bus1.we_o), we1);
      checkOutput("wr_valid_lat4", 32'(bus4.wr_valid), 32'(histV[h4]));
      checkOutput("waddr_lat4", 32'({bus4.waddr1_o, bus4.waddr2_o}), 32'(histA1[h4] * 32 + histA2[h4]));
      checkOutput("we_lat4", 32'(bus4.we_o), we4);

      checkOutput("done_lat1", 32'(bus1.done), 32'(lastRd >= 0 && cyc == lastRd + 2));
      checkOutput("done_lat4", 32'(bus4.done), 32'(lastRd >= 0 && cyc == lastRd + 5));
      checkOutput("busy_lat1", 32'(bus1.busy), 32'(!(lastRd >= 0 && cyc >= lastRd + 2)));
      checkOutput("busy_lat4", 32'(bus4.busy), 32'(!(lastRd >= 0 && cyc >= lastRd + 5)));
      obsDone1 += int'(bus1.done);
      obsDone4 += int'(bus4.done);

      if (expV && (issued - 1) == stallAfter) stallLeft = 3;
      stall = (stallLeft > 0);
      if (stallLeft > 0) stallLeft--;
      start = (cyc == restartCycle);
      if (start) inverse = 1'b1;

      if (abortAfter >= 0 && issued > abortAfter) break;
      if (lastRd >= 0 && cyc == lastRd + 7) begin
        runFinished = 1;
        break;
      end
    end
    stall  = 1'b0;
    start  = 1'b0;
    holdA1 = ea1;
    holdA2 = ea2;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    inverse = 1'b0;
    stall   = 1'b0;
    tick();
    tick();
    checkResetState("por");
    rst_n = 1'b1;
    tick();
    checkResetState("after_release");

    $display("[TB] forward transform");
    runTransform(1'b0, -1, -1, -1);
    checkOutput("fwd_finished", 32'(runFinished), 32'd1);
    checkOutput("fwd_rd_count", 32'(obsRd), 32'd80);
    checkOutput("fwd_update_m_count", 32'(obsUm), 32'd5);
    checkOutput("fwd_update_omega_count", 32'(obsUo), 32'd30);
    checkOutput("fwd_done1_count", 32'(obsDone1), 32'd1);
    checkOutput("fwd_done4_count", 32'(obsDone4), 32'd1);
    checkOutput("fwd_first_pair", 32'(pairFirst), 32'd1);
    checkOutput("fwd_second_pair", 32'(pairSecond), 32'd203);
    checkOutput("fwd_last_pair", 32'(pairLast), 32'd1531);
    checkOutput("fwd_gap", 32'(obsGap), 32'd0);

    $display("[TB] inverse transform");
    runTransform(1'b1, -1, -1, -1);
    checkOutput("inv_finished", 32'(runFinished), 32'd1);
    checkOutput("inv_rd_count", 32'(obsRd), 32'd80);
    checkOutput("inv_update_m_count", 32'(obsUm), 32'd5);
    checkOutput("inv_update_omega_count", 32'(obsUo), 32'd30);
    checkOutput("inv_first_pair", 32'(pairFirst), 32'd16);
    checkOutput("inv_second_pair", 32'(pairSecond), 32'd117);
    checkOutput("inv_last_pair", 32'(pairLast), 32'd3031);
    checkOutput("inv_done1_count", 32'(obsDone1), 32'd1);

    $display("[TB] stall after pair (4,6)");
    runTransform(1'b0, 17, -1, -1);
    checkOutput("stall_finished", 32'(runFinished), 32'd1);
    checkOutput("stall_gap", 32'(obsGap), 32'd3);
    checkOutput("stall_resume_pair", 32'(pairResume), 32'd810);
    checkOutput("stall_rd_count", 32'(obsRd), 32'd80);

    $display("[TB] start while busy");
    runTransform(1'b0, -1, 30, -1);
    checkOutput("restart_finished", 32'(runFinished), 32'd1);
    checkOutput("restart_rd_count", 32'(obsRd), 32'd80);
    checkOutput("restart_done1_count", 32'(obsDone1), 32'd1);
    checkOutput("restart_done4_count", 32'(obsDone4), 32'd1);
    checkOutput("restart_last_pair", 32'(pairLast), 32'd1531);

    $display("[TB] reset mid stage 2");
    runTransform(1'b0, -1, -1, 40);
    rst_n = 1'b0;
    #1;
    checkResetState("mid_reset");
    tick();
    rst_n  = 1'b1;
    holdA1 = 0;
    holdA2 = 0;
    tick();
    runTransform(1'b0, -1, -1, -1);
    checkOutput("post_reset_finished", 32'(runFinished), 32'd1);
    checkOutput("post_reset_first_pair", 32'(pairFirst), 32'd1);
    checkOutput("post_reset_rd_count", 32'(obsRd), 32'd80);
    checkOutput("post_reset_last_pair", 32'(pairLast), 32'd1531);
    checkOutput("post_reset_done1_count", 32'(obsDone1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
